// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hub75_pkg
// Description : Shared HUB75 types: capture state encoding, colour-bit and
//               row-address ordering used by both bus endpoints.
// Revision    : 1.0 - initial release
// ============================================================================
package hub75_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    localparam int C_COLOUR_W = 6;

    // Colour bits travel as {R1,G1,B1,R2,G2,B2}: upper segment in the MSBs.
    function automatic logic [C_COLOUR_W-1:0] pack_colour(
        input logic r1, input logic g1, input logic b1,
        input logic r2, input logic g2, input logic b2
    );
        return {r1, g1, b1, r2, g2, b2};
    endfunction

    // Row address: A is the MSB.
    function automatic logic [3:0] row_addr(
        input logic a, input logic b, input logic c, input logic d
    );
        return {a, b, c, d};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_input_sync.sv
`default_nettype none
// ============================================================================
// Module      : hub75_input_sync
// Description : 2-FF synchroniser for HUB75 pins with rising-edge detection
//               on the shift clock and latch strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_input_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clk_pin,
    input  logic             i_stb_pin,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_clk_rise,
    output logic             o_stb_rise
);

    logic [WIDTH+1:0] r_meta;
    logic [WIDTH+1:0] r_sync;
    logic             r_clk_prev;
    logic             r_stb_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta     <= '0;
            r_sync     <= '0;
            r_clk_prev <= 1'b0;
            r_stb_prev <= 1'b0;
        end else begin
            r_meta     <= {i_clk_pin, i_stb_pin, i_data};
            r_sync     <= r_meta;
            r_clk_prev <= r_sync[WIDTH+1];
            r_stb_prev <= r_sync[WIDTH];
        end
    end

    assign o_data     = r_sync[WIDTH-1:0];
    assign o_clk_rise = r_sync[WIDTH+1] & ~r_clk_prev;
    assign o_stb_rise = r_sync[WIDTH]   & ~r_stb_prev;

endmodule
`default_nettype wire

// File: rtl/hub75_capture.sv
`default_nettype none
// ============================================================================
// Module      : hub75_capture
// Description : HUB75 receive monitor. Rebuilds each latched row/bit-plane,
//               dumps it to a capture memory and measures OE on-time.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_capture
    import hub75_pkg::*;
#(
    parameter  int HPIXEL_P     = 64,
    parameter  int ROWS_P       = 16,
    parameter  int BPP_P        = 8,
    parameter  int CNT_WIDTH_P  = 16,
    localparam int ADDR_WIDTH_P = $clog2(ROWS_P) + $clog2(BPP_P) + $clog2(HPIXEL_P)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic                    O_CLK,
    input  logic                    STB,
    input  logic                    OE,
    input  logic                    A,
    input  logic                    B,
    input  logic                    C,
    input  logic                    D,
    input  logic                    R1,
    input  logic                    G1,
    input  logic                    B1,
    input  logic                    R2,
    input  logic                    G2,
    input  logic                    B2,
    output logic                    o_wr_en,
    output logic [ADDR_WIDTH_P-1:0] o_wr_addr,
    output logic [5:0]              o_wr_data,
    output logic [CNT_WIDTH_P-1:0]  o_on_cycles,
    output logic                    o_on_valid,
    output logic                    o_short_row,
    output logic                    o_overrun
);

    localparam int ROW_W   = $clog2(ROWS_P);
    localparam int PLANE_W = $clog2(BPP_P);
    localparam int COL_W   = $clog2(HPIXEL_P);
    localparam int SHC_W   = $clog2(HPIXEL_P + 1);
    localparam int SHIFT_W = C_COLOUR_W * HPIXEL_P;
    localparam int SYNC_W  = 1 + 4 + C_COLOUR_W;

    localparam logic [SHC_W-1:0]   C_SH_FULL    = SHC_W'(HPIXEL_P);
    localparam logic [COL_W-1:0]   C_COL_LAST   = COL_W'(HPIXEL_P - 1);
    localparam logic [PLANE_W-1:0] C_PLANE_LAST = PLANE_W'(BPP_P - 1);

    logic [SYNC_W-1:0]     w_sync;
    logic                  w_clk_rise;
    logic                  w_stb_rise;
    logic                  w_oe;
    logic [ROW_W-1:0]      w_row;
    logic [C_COLOUR_W-1:0] w_colour;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_active;
    logic                  w_arm;
    logic                  w_latch;
    logic                  w_drop;

    logic [SHIFT_W-1:0]    r_shift;
    logic [SHIFT_W-1:0]    w_shift_next;
    logic [SHC_W-1:0]      r_sh_cnt;
    logic [SHC_W-1:0]      w_sh_cnt_next;
    logic [SHIFT_W-1:0]    r_shadow;
    logic [ROW_W-1:0]      r_row;
    logic [PLANE_W-1:0]    r_plane;
    logic [PLANE_W-1:0]    w_plane_next;
    logic                  r_latched;
    logic [COL_W-1:0]      r_col;
    logic [CNT_WIDTH_P-1:0] r_oe_cnt;
    logic [CNT_WIDTH_P-1:0] w_oe_inc;
    logic                  r_on_seen;

    hub75_input_sync #(
        .WIDTH (SYNC_W)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_clk_pin  (O_CLK),
        .i_stb_pin  (STB),
        .i_data     ({OE, A, B, C, D, pack_colour(R1, G1, B1, R2, G2, B2)}),
        .o_data     (w_sync),
        .o_clk_rise (w_clk_rise),
        .o_stb_rise (w_stb_rise)
    );

    assign w_oe     = w_sync[SYNC_W-1];
    assign w_row    = ROW_W'(row_addr(w_sync[9], w_sync[8], w_sync[7], w_sync[6]));
    assign w_colour = w_sync[C_COLOUR_W-1:0];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_enable) w_state_next = ST_ARMED;
            ST_ARMED: begin
                if (!i_enable)      w_state_next = ST_IDLE;
                else if (w_stb_rise) w_state_next = ST_DUMP;
            end
            ST_DUMP:  if (r_col == C_COL_LAST) w_state_next = i_enable ? ST_ARMED : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_wr_en  = (r_state == ST_DUMP);
        w_active = (r_state != ST_IDLE);
        w_arm    = (r_state == ST_IDLE) && i_enable;
        w_latch  = (r_state == ST_ARMED) && i_enable && w_stb_rise;
        w_drop   = (r_state == ST_DUMP) && w_stb_rise;
    end

    // ---------------------------------------------------------- shift path
    // A shift coincident with a strobe lands before the shadow copy.
    assign w_shift_next  = w_clk_rise ? {r_shift[SHIFT_W-C_COLOUR_W-1:0], w_colour} : r_shift;
    assign w_sh_cnt_next = (w_clk_rise && r_sh_cnt != C_SH_FULL) ? r_sh_cnt + 1'b1 : r_sh_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_sh_cnt <= '0;
        end else begin
            r_shift  <= w_shift_next;
            r_sh_cnt <= w_stb_rise ? '0 : w_sh_cnt_next;
        end
    end

    // ---------------------------------------------------------- latch path
    always_comb begin
        w_plane_next = '0;
        if (r_latched && w_row == r_row)
            w_plane_next = (r_plane == C_PLANE_LAST) ? r_plane : r_plane + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow    <= '0;
            r_row       <= '0;
            r_plane     <= '0;
            r_latched   <= 1'b0;
            r_col       <= '0;
            o_short_row <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (w_latch) begin
                r_shadow  <= w_shift_next;
                r_row     <= w_row;
                r_plane   <= w_plane_next;
                r_latched <= 1'b1;
                r_col     <= '0;
            end else if (o_wr_en) begin
                r_col     <= r_col + 1'b1;
            end
            if (w_arm) begin
                r_latched   <= 1'b0;
                o_short_row <= 1'b0;
                o_overrun   <= 1'b0;
            end else begin
                if (w_latch && w_sh_cnt_next < C_SH_FULL) o_short_row <= 1'b1;
                if (w_drop)                                o_overrun   <= 1'b1;
            end
        end
    end

    assign o_wr_addr = {r_row, r_plane, r_col};
    assign o_wr_data = r_shadow[int'(r_col) * C_COLOUR_W +: C_COLOUR_W];

    // ------------------------------------------------------ OE on-time
    // The strobe cycle's own increment is part of the reported value.
    assign w_oe_inc = (w_active && !w_oe && r_oe_cnt != '1) ? r_oe_cnt + 1'b1 : r_oe_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oe_cnt  <= '0;
            r_on_seen <= 1'b0;
        end else if (!w_active) begin
            r_oe_cnt  <= '0;
            r_on_seen <= 1'b0;
        end else begin
            r_oe_cnt  <= w_stb_rise ? '0 : w_oe_inc;
            if (w_stb_rise) r_on_seen <= 1'b1;
        end
    end

    assign o_on_valid  = w_active && w_stb_rise && r_on_seen;
    assign o_on_cycles = o_on_valid ? w_oe_inc : '0;

endmodule
`default_nettype wire

// File: tb/tb_hub75_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_capture
// Description : Scoreboard bench for hub75_capture with a row-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        O_CLK = 1'b0, STB = 1'b0, OE = 1'b1;
    logic        A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic        R1 = 1'b0, G1 = 1'b0, B1 = 1'b0, R2 = 1'b0, G2 = 1'b0, B2 = 1'b0;
    logic        o_wr_en;
    logic [12:0] o_wr_addr;
    logic [5:0]  o_wr_data;
    logic [15:0] o_on_cycles;
    logic        o_on_valid;
    logic        o_short_row;
    logic        o_overrun;

    always #5 clk = ~clk;

    hub75_capture dut (
        .clk (clk), .rst (rst), .i_enable (i_enable),
        .O_CLK (O_CLK), .STB (STB), .OE (OE),
        .A (A), .B (B), .C (C), .D (D),
        .R1 (R1), .G1 (G1), .B1 (B1), .R2 (R2), .G2 (G2), .B2 (B2),
        .o_wr_en (o_wr_en), .o_wr_addr (o_wr_addr), .o_wr_data (o_wr_data),
        .o_on_cycles (o_on_cycles), .o_on_valid (o_on_valid),
        .o_short_row (o_short_row), .o_overrun (o_overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a row is a list of 64 colour words, newest at index 0.
    logic [5:0]  m_sh [64];
    int          m_cnt, m_prev_row, m_plane, m_pending;
    bit          m_latched, m_seen, m_short, m_over;
    logic [18:0] exp_wr [$];
    int          exp_on [$];
    int          n_writes = 0;
    logic [18:0] mon_w;
    int          mon_o;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_wr_en) begin
                n_writes++;
                if (exp_wr.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write", o_wr_addr, o_wr_data);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", 64'(o_wr_addr), 64'(mon_w[18:6]));
                    check("wr_data", 64'(o_wr_data), 64'(mon_w[5:0]));
                end
            end
            if (o_on_valid) begin
                if (exp_on.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL on_unexpected: got pulse with %0d, expected none", o_on_cycles);
                end else begin
                    mon_o = exp_on.pop_front();
                    check("on_cycles", 64'(o_on_cycles), 64'(mon_o));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_sh[i] = '0;
        m_cnt = 0; m_prev_row = 0; m_plane = 0; m_pending = 0;
        m_latched = 0; m_seen = 0; m_short = 0; m_over = 0;
    endtask

    task automatic shift_col(input logic [5:0] c);
        for (int i = 63; i > 0; i--) m_sh[i] = m_sh[i-1];
        m_sh[0] = c;
        if (m_cnt < 64) m_cnt++;
        {R1, G1, B1, R2, G2, B2} = c;
        O_CLK = 1'b1; cyc(3);
        O_CLK = 1'b0; cyc(3);
    endtask

    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++) shift_col(6'($urandom));
    endtask

    task automatic latch(input int row, input bit acc);
        logic [3:0] r4;
        r4 = row[3:0];
        if (m_seen) exp_on.push_back(m_pending > 65535 ? 65535 : m_pending);
        m_seen = 1; m_pending = 0;
        if (acc) begin
            if (m_cnt < 64) m_short = 1;
            if (!m_latched || row != m_prev_row) m_plane = 0;
            else if (m_plane < 7)                m_plane = m_plane + 1;
            m_prev_row = row; m_latched = 1;
            for (int c = 0; c < 64; c++)
                exp_wr.push_back({r4, 3'(m_plane), 6'(c), m_sh[c]});
        end else begin
            m_over = 1;
        end
        m_cnt = 0;
        {A, B, C, D} = r4;
        STB = 1'b1; cyc(3);
        STB = 1'b0; cyc(3);
    endtask

    task automatic oe_low(input int n);
        OE = 1'b0; cyc(n);
        OE = 1'b1; cyc(4);
        m_pending += n;
    endtask

    task automatic arm();
        i_enable = 1'b0; cyc(3);
        i_enable = 1'b1; cyc(3);
        m_latched = 0; m_seen = 0; m_short = 0; m_over = 0; m_pending = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_wr.size() != 0 && t < 300) begin cyc(1); t++; end
        if (exp_wr.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: %0d writes outstanding, expected 0", exp_wr.size());
            exp_wr.delete();
        end
        cyc(4);
    endtask

    task automatic check_flags();
        check("short_row", 64'(o_short_row), 64'(m_short));
        check("overrun",   64'(o_overrun),   64'(m_over));
    endtask

    function automatic logic [38:0] all_outputs();
        return {o_wr_en, o_wr_addr, o_wr_data, o_on_cycles, o_on_valid, o_short_row, o_overrun};
    endfunction

    initial begin
        int base, t;
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        model_reset();
        cyc(3);
        check("reset_outputs", 64'(all_outputs()), 64'd0);
        rst = 1'b0; cyc(2);

        // Single full latch on row 5
        arm();
        for (int i = 0; i < 64; i++) shift_col((i % 2) ? 6'h15 : 6'h2A);
        latch(5, 1); drain(); check_flags();

        // On-time of 128 cycles
        oe_low(128);
        latch(5, 1); drain(); check_flags();

        // Plane advance and saturation, then row change
        arm();
        for (int k = 0; k < 9; k++) begin shift_rand(8); latch(3, 1); drain(); end
        check("plane_sat", 64'(m_plane), 64'd7);
        shift_rand(8); latch(4, 1); drain(); check_flags();

        // Short row
        arm();
        shift_rand(40); latch(7, 1); drain(); check_flags();

        // Overrun: second strobe ten writes into a dump
        arm();
        shift_rand(64);
        base = n_writes;
        latch(2, 1);
        t = 0;
        while (n_writes < base + 10 && t < 200) begin cyc(1); t++; end
        check("overrun_wait", 64'(n_writes >= base + 10), 64'd1);
        latch(2, 0); drain(); check_flags();
        shift_rand(4); latch(2, 1); drain();

        // Randomised rows with random on-time
        arm();
        for (int k = 0; k < 6; k++) begin
            if ($urandom % 2) oe_low($urandom_range(1, 60));
            shift_rand(($urandom % 2) ? 64 : $urandom_range(1, 63));
            latch($urandom_range(6, 7), 1); drain(); check_flags();
        end

        // On-time counter saturation
        oe_low(65600);
        latch(6, 1); drain();

        // Asynchronous reset in the middle of a burst
        arm();
        shift_rand(64);
        base = n_writes;
        latch(9, 1);
        t = 0;
        while (n_writes < base + 20 && t < 200) begin cyc(1); t++; end
        check("reset_wait", 64'(n_writes >= base + 20), 64'd1);
        rst = 1'b1; #1;
        check("reset_mid_burst", 64'(all_outputs()), 64'd0);
        exp_wr.delete();
        model_reset();
        cyc(3);
        rst = 1'b0; cyc(3);
        shift_rand(64); latch(9, 1); drain(); check_flags();

        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("on_queue_empty", 64'(exp_on.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
